// File: rtl/even_parity_tx.sv
`default_nettype none
// ============================================================================
// Module   : even_parity_tx
// Purpose  : Serial transmitter: start bit, data LSB first, even parity, stop.
// Revision : 1.0 - initial release
// ============================================================================
module even_parity_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    output logic              ready_out,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam int c_timer_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_index_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [c_timer_w-1:0] c_last_tick = c_timer_w'(CLKS_PER_BIT - 1);
    localparam logic [c_index_w-1:0] c_last_bit  = c_index_w'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               r_state, w_state_n;
    logic [c_timer_w-1:0] r_timer, w_timer_n;
    logic [c_index_w-1:0] r_index, w_index_n;
    logic [DATA_W-1:0]    r_shift, w_shift_n;
    logic                 r_parity, w_parity_n;
    logic                 r_tx, w_tx_n;

    logic w_wrap;
    logic w_accept;

    assign w_wrap     = (r_timer == c_last_tick);
    assign ready_out  = (r_state == S_IDLE) || ((r_state == S_STOP) && w_wrap);
    assign frame_done = (r_state == S_STOP) && w_wrap;
    assign busy       = (r_state != S_IDLE);
    assign w_accept   = valid_in && ready_out;
    assign tx_out     = r_tx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_timer  <= '0;
            r_index  <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
        end else begin
            r_state  <= w_state_n;
            r_timer  <= w_timer_n;
            r_index  <= w_index_n;
            r_shift  <= w_shift_n;
            r_parity <= w_parity_n;
            r_tx     <= w_tx_n;
        end
    end

    always_comb begin
        w_state_n  = r_state;
        w_timer_n  = w_wrap ? '0 : r_timer + 1'b1;
        w_index_n  = r_index;
        w_shift_n  = r_shift;
        w_parity_n = r_parity;

        case (r_state)
            S_IDLE: begin
                w_timer_n = '0;
                if (w_accept) begin
                    w_state_n  = S_START;
                    w_shift_n  = data_in;
                    w_parity_n = ^data_in;
                    w_index_n  = '0;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_n = S_DATA;
                    w_index_n = '0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_shift_n = r_shift >> 1;
                    if (r_index == c_last_bit) begin
                        w_state_n = S_PARITY;
                    end else begin
                        w_index_n = r_index + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (w_wrap) begin
                    w_state_n = S_STOP;
                end
            end
            S_STOP: begin
                // The final stop cycle doubles as an acceptance slot for back-to-back frames
                if (w_wrap) begin
                    if (w_accept) begin
                        w_state_n  = S_START;
                        w_shift_n  = data_in;
                        w_parity_n = ^data_in;
                        w_index_n  = '0;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_n = S_IDLE;
                w_timer_n = '0;
            end
        endcase

        // Line level is registered from the next state so the pin never glitches
        case (w_state_n)
            S_START:  w_tx_n = 1'b0;
            S_DATA:   w_tx_n = w_shift_n[0];
            S_PARITY: w_tx_n = w_parity_n;
            default:  w_tx_n = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/even_parity_tx.md
# even_parity_tx

Serial transmitter that frames parallel data words with an even-parity bit and shifts them out on a single line. It sits directly downstream of the even-parity generator stage: it takes a word over a valid/ready handshake and computes the parity bit internally as the XOR of all data bits. It then emits a start bit, the data bits LSB first, the parity bit and a stop bit. It feeds the board-level serial pin or a loopback checker.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- CLKS_PER_BIT, 16, clock cycles per serial bit (≥1); bit-timer width is $clog2(CLKS_PER_BIT), minimum 1
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, asynchronous, active-high
- data_in  input  DATA_W  word to transmit; sampled only on acceptance
- valid_in  input  1  data_in is valid
- ready_out  output  1  block can accept a word this cycle
- tx_out  output  1  serial line, idle high
- busy  output  1  a frame is in progress (any state except IDLE)
- frame_done  output  1  single-cycle pulse on the last cycle of the stop bit

## Operation
- Reset (async, active-high): state=IDLE, tx_out=1, ready_out=1, busy=0, frame_done=0, bit timer=0, bit index=0, shift register=0. Deassertion is synchronous to clk by the integrating design.
- Acceptance occurs on a rising edge where valid_in && ready_out. On acceptance:
  - latch data_in into the shift register;
  - latch parity = XOR-reduce(data_in), so the total count of ones in data plus parity is even;
  - go to START.
- States:
  - IDLE: tx_out=1, ready_out=1.
  - START: tx_out=0.
  - DATA: tx_out=shift[0], and the register shifts right at each bit boundary; bit index counts 0..DATA_W-1.
  - PARITY: tx_out=latched parity.
  - STOP: tx_out=1.
- Each of START, each data bit, PARITY and STOP lasts exactly CLKS_PER_BIT cycles. The bit timer counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
- State transitions:
  - START→DATA at timer wrap.
  - DATA→PARITY at timer wrap when bit index=DATA_W-1.
  - PARITY→STOP at timer wrap.
  - STOP→IDLE at timer wrap, or STOP→START at timer wrap if a word is accepted on that edge.
- ready_out=1 in IDLE, and also during the final cycle of STOP (timer=CLKS_PER_BIT-1). This allows back-to-back frames with no idle gap. ready_out=0 in all other cycles.
- frame_done=1 exactly in the final STOP cycle, coincident with the late ready_out.
- data_in and valid_in are ignored while ready_out=0. Changes to data_in during a frame do not affect the frame in flight.
- Reset mid-frame aborts the frame immediately: tx_out returns to 1 asynchronously and the latched word is discarded, with no frame_done.

## Timing
- Registered outputs; tx_out is driven from state/shift registers, never combinationally from inputs. ready_out and busy decode from state and timer.
- Latency: acceptance at edge N puts tx_out=0 from edge N (after the clock-to-output delay) through edge N+CLKS_PER_BIT.
- Frame length: (DATA_W+3)·CLKS_PER_BIT cycles from acceptance to the STOP→IDLE/START transition.
- Sustained throughput with valid_in held high: one word per (DATA_W+3)·CLKS_PER_BIT cycles.
- CLKS_PER_BIT=1: every state lasts 1 cycle, so ready_out is high throughout the single STOP cycle.

## Test plan
- DATA_W=8, CLKS_PER_BIT=4, send 0xA5 -> required line sequence, each level held 4 cycles:
  - 0 (start); 1,0,1,0,0,1,0,1 (LSB first); 0 (parity, four ones); 1 (stop);
  - frame_done pulses once at cycle 43 after acceptance.
- Send 0x07 -> parity bit 1 (three ones); send 0x00 -> parity 0; send 0xFF -> parity 0. Each frame is 44 cycles.
- valid_in held high with words 0x01, 0x02, 0x03 -> three contiguous frames:
  - no idle-high gap between STOP and the next START;
  - ready_out high only in each final STOP cycle;
  - three frame_done pulses, 44 cycles apart.
- Assert rst during the 3rd data bit of 0x5A -> tx_out=1 and ready_out=1 immediately, busy=0, no frame_done. The next word, 0x3C, transmits a clean frame.
- Change data_in and toggle valid_in during a frame of 0x81 -> transmitted bits are still 0x81 with parity 0. No extra acceptance occurs before the final STOP cycle.
- CLKS_PER_BIT=1, DATA_W=3, send 3'b110 -> tx_out sequence 0,0,1,1,0,1 over 6 cycles (parity 0). Back-to-back words are accepted every 6 cycles.
